// File: rtl/lisnoc_converter_downsize.sv
// LISNoC width downsizer: buffers wide flits from several input VCs and
// serializes them into narrow flits on one output VC.
module lisnoc_converter_downsize #(
    parameter int         IN_DATA_WIDTH = 32,
    parameter int         RATIO         = 2,
    parameter int         FIFO_DEPTH    = 16,
    parameter int         VCHANNELS_IN  = 3,
    parameter int         VCHANNELS_OUT = 1,
    parameter int         OUT_VC        = 0,
    parameter int         GEN_HEADER    = 1,
    parameter logic [4:0] DEST          = 5'd0,
    parameter logic [2:0] PKT_CLASS     = 3'b111,
    parameter int         MSB_FIRST     = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [IN_DATA_WIDTH+1:0]           in_flit,
    input  logic [VCHANNELS_IN-1:0]            in_valid,
    output logic [VCHANNELS_IN-1:0]            in_ready,
    output logic [IN_DATA_WIDTH/RATIO+1:0]     out_flit,
    output logic [VCHANNELS_OUT-1:0]           out_valid,
    input  logic [VCHANNELS_OUT-1:0]           out_ready
);

    localparam int OW  = IN_DATA_WIDTH / RATIO;
    localparam int FW  = IN_DATA_WIDTH + 2;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int VCW = (VCHANNELS_IN > 1) ? $clog2(VCHANNELS_IN) : 1;
    localparam int CW  = $clog2(RATIO);

    localparam logic [OW+7:0] HDR_FULL = {DEST, PKT_CLASS, {OW{1'b0}}};
    localparam logic [OW-1:0] HDR_DATA = HDR_FULL[OW+7 -: OW];

    typedef enum logic [1:0] {
        T_PAYLOAD = 2'b00,
        T_HEADER  = 2'b01,
        T_LAST    = 2'b10,
        T_SINGLE  = 2'b11
    } flit_type_e;

    typedef enum logic {
        S_HDR,
        S_SLICE
    } state_e;

    localparam state_e S_INIT = (GEN_HEADER != 0) ? S_HDR : S_SLICE;

    // ---------------- input arbitration ----------------
    logic [VCW-1:0] rr_ptr;
    logic [VCW-1:0] lock_vc;
    logic           locked;
    logic [VCW-1:0] grant;
    logic           grant_vld;
    logic           push;
    logic           full;
    logic           empty;
    flit_type_e     in_type;
    int             j;

    assign in_type = flit_type_e'(in_flit[FW-1 -: 2]);

    // Round-robin search starts at rr_ptr; a locked packet bypasses it
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        j         = 0;
        if (locked) begin
            grant     = lock_vc;
            grant_vld = in_valid[lock_vc];
        end else begin
            for (int i = 0; i < VCHANNELS_IN; i++) begin
                j = int'(rr_ptr) + i;
                if (j >= VCHANNELS_IN)
                    j = j - VCHANNELS_IN;
                if (!grant_vld && in_valid[j[VCW-1:0]]) begin
                    grant_vld = 1'b1;
                    grant     = j[VCW-1:0];
                end
            end
        end
    end

    assign push = grant_vld && !full && !rst;

    always_comb begin
        in_ready = '0;
        if (push)
            in_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            locked  <= 1'b0;
            lock_vc <= '0;
        end else if (push) begin
            if (int'(grant) == VCHANNELS_IN - 1)
                rr_ptr <= '0;
            else
                rr_ptr <= grant + VCW'(1);
            if (in_type == T_HEADER) begin
                locked  <= 1'b1;
                lock_vc <= grant;
            end else if (in_type == T_LAST) begin
                locked  <= 1'b0;
            end
        end
    end

    // ---------------- flit FIFO ----------------
    logic [FW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          pop;
    logic [FW-1:0] head;
    flit_type_e    head_type;
    logic [IN_DATA_WIDTH-1:0] head_data;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= in_flit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign head      = mem[rd_ptr[AW-1:0]];
    assign head_type = flit_type_e'(head[FW-1 -: 2]);
    assign head_data = head[IN_DATA_WIDTH-1:0];

    // ---------------- serializer ----------------
    state_e        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          head_starts;
    logic          head_ends;
    logic          last_slice;
    logic          gen_hdr_beat;
    int            sidx;
    logic [OW-1:0] slice;
    flit_type_e    beat_type;
    logic          unused_ready;

    assign unused_ready = ^out_ready;

    assign head_starts  = (head_type == T_HEADER) || (head_type == T_SINGLE);
    assign head_ends    = (head_type == T_LAST) || (head_type == T_SINGLE);
    assign last_slice   = (cnt == CW'(RATIO - 1));
    // Payload/last at the head while in HDR is sliced directly
    assign gen_hdr_beat = (GEN_HEADER != 0) && (state == S_HDR) && head_starts;

    assign sidx  = (MSB_FIRST != 0) ? (RATIO - 1 - int'(cnt)) : int'(cnt);
    assign slice = head_data[sidx*OW +: OW];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        out_valid = '0;
        out_flit  = '0;
        beat_type = T_PAYLOAD;
        if (!rst && !empty) begin
            out_valid[OUT_VC] = 1'b1;
            if (gen_hdr_beat) begin
                out_flit = {T_HEADER, HDR_DATA};
                if (out_ready[OUT_VC]) begin
                    state_nxt = S_SLICE;
                    cnt_nxt   = '0;
                end
            end else begin
                if (last_slice && head_ends)
                    beat_type = T_LAST;
                else if (GEN_HEADER == 0 && cnt == '0 && head_starts)
                    beat_type = T_HEADER;
                out_flit = {beat_type, slice};
                if (out_ready[OUT_VC]) begin
                    if (last_slice) begin
                        pop     = 1'b1;
                        cnt_nxt = '0;
                        if (GEN_HEADER != 0 && head_ends)
                            state_nxt = S_HDR;
                        else
                            state_nxt = S_SLICE;
                    end else begin
                        cnt_nxt   = cnt + CW'(1);
                        state_nxt = S_SLICE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lisnoc_converter_downsize.sv
// Directed bench for lisnoc_converter_downsize: default build plus a
// GEN_HEADER=0, RATIO=4, LSB-first build.
module tb_lisnoc_converter_downsize;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [33:0] in_flit;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [17:0] out_flit;
    logic [0:0]  out_valid;
    logic [0:0]  out_ready;

    logic [33:0] d2_in_flit;
    logic [2:0]  d2_in_valid;
    logic [2:0]  d2_in_ready;
    logic [9:0]  d2_out_flit;
    logic [0:0]  d2_out_valid;
    logic [0:0]  d2_out_ready;

    lisnoc_converter_downsize dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    lisnoc_converter_downsize #(
        .RATIO      (4),
        .GEN_HEADER (0),
        .MSB_FIRST  (0)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (d2_in_flit),
        .in_valid  (d2_in_valid),
        .in_ready  (d2_in_ready),
        .out_flit  (d2_out_flit),
        .out_valid (d2_out_valid),
        .out_ready (d2_out_ready)
    );

    typedef struct {
        int          vc;
        logic [33:0] flit;
        int          nb;
        logic [17:0] e [3];
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [33:0] src0[$];
    logic [33:0] src1[$];
    logic [33:0] src2[$];
    logic [17:0] exp_q[$];
    vec_t        tbl[5];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_chk(input string name);
        @(negedge clk);
        #1;
        chk({name, "_valid"}, out_valid, 0);
        chk({name, "_flit"}, out_flit, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = '0;
        @(negedge clk);
        rst      = 1'b0;
    endtask

    // Feeds src queues through the arbiter and checks every output beat
    task automatic run(input bit toggle, input bit gapchk,
                       input bit latchk, input int maxc);
        int          cyc;
        bit          started;
        bit          pushed;
        bit          pv;
        bit          pr;
        logic [17:0] pf;
        int          push_cyc;
        cyc = 0; started = 0; pushed = 0;
        pv = 0; pr = 1; pf = '0; push_cyc = 0;
        while ((exp_q.size() != 0 || src0.size() != 0 ||
                src1.size() != 0 || src2.size() != 0) && cyc < maxc) begin
            @(negedge clk);
            out_ready[0] = toggle ? (cyc % 2 == 0) : 1'b1;
            in_valid = {src2.size() != 0, src1.size() != 0,
                        src0.size() != 0};
            #1;
            chk("ready_onehot", ($countones(in_ready) <= 1), 1);
            case (in_ready)
                3'b001: in_flit = src0.pop_front();
                3'b010: in_flit = src1.pop_front();
                3'b100: in_flit = src2.pop_front();
                default: ;
            endcase
            if (in_ready != 0 && !pushed) begin
                pushed   = 1;
                push_cyc = cyc;
            end
            if (pv && !pr) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_flit", out_flit, pf);
            end
            if (out_valid[0]) begin
                if (!started && latchk)
                    chk("first_beat_latency", cyc - push_cyc, 1);
                started = 1;
                if (out_ready[0]) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL extra_beat: got 0x%0h, want none",
                                 out_flit);
                    end else begin
                        chk("beat", out_flit, exp_q.pop_front());
                    end
                end
            end else if (gapchk && started && exp_q.size() != 0) begin
                chk("beat_gap", out_valid, 1);
            end
            pv = out_valid[0];
            pr = out_ready[0];
            pf = out_flit;
            cyc++;
        end
        if (exp_q.size() != 0 || src0.size() != 0 ||
            src1.size() != 0 || src2.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL run_timeout: got %0d beats left, want 0",
                     exp_q.size());
            exp_q.delete();
            src0.delete(); src1.delete(); src2.delete();
        end
        in_valid = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, {2'b11, 32'hAABBCCDD}, 3,
                   '{18'h10700, 18'h0AABB, 18'h2CCDD}};
        tbl[1] = '{1, {2'b11, 32'h12345678}, 3,
                   '{18'h10700, 18'h01234, 18'h25678}};
        tbl[2] = '{2, {2'b11, 32'h0000FFFF}, 3,
                   '{18'h10700, 18'h00000, 18'h2FFFF}};
        tbl[3] = '{0, {2'b00, 32'hDEADBEEF}, 2,
                   '{18'h0DEAD, 18'h0BEEF, 18'h0}};
        tbl[4] = '{1, {2'b10, 32'hCAFEF00D}, 2,
                   '{18'h0CAFE, 18'h2F00D, 18'h0}};

        rst          = 1'b1;
        in_flit      = {2'b11, 32'h12345678};
        in_valid     = 3'b111;
        out_ready    = 1'b1;
        d2_in_flit   = '0;
        d2_in_valid  = 3'b111;
        d2_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_flit", out_flit, 0);
        chk("rst_d2_in_ready", d2_in_ready, 0);
        chk("rst_d2_out_valid", d2_out_valid, 0);
        @(negedge clk);
        rst         = 1'b0;
        in_valid    = '0;
        d2_in_valid = '0;

        // single flits and headerless payload/last
        for (int i = 0; i < 5; i++) begin
            case (tbl[i].vc)
                0: src0.push_back(tbl[i].flit);
                1: src1.push_back(tbl[i].flit);
                default: src2.push_back(tbl[i].flit);
            endcase
            for (int k = 0; k < tbl[i].nb; k++)
                exp_q.push_back(tbl[i].e[k]);
            run(1'b0, 1'b1, 1'b1, 50);
            idle_chk("vec_idle");
        end

        // header + payload + last on VC1 with out_ready toggling
        src1.push_back({2'b01, 32'h11112222});
        src1.push_back({2'b00, 32'h33334444});
        src1.push_back({2'b10, 32'h55556666});
        exp_q = '{18'h10700, 18'h01111, 18'h02222, 18'h03333,
                  18'h04444, 18'h05555, 18'h26666};
        run(1'b1, 1'b0, 1'b1, 60);
        idle_chk("toggle_idle");

        // two VCs contending: VC0 packet wins whole, then VC2
        do_reset();
        src0.push_back({2'b01, 32'hA0A0A0A0});
        src0.push_back({2'b00, 32'hA1A1A1A1});
        src0.push_back({2'b10, 32'hA2A2A2A2});
        src2.push_back({2'b01, 32'hB0B0B0B0});
        src2.push_back({2'b10, 32'hB1B1B1B1});
        exp_q = '{18'h10700, 18'h0A0A0, 18'h0A0A0, 18'h0A1A1,
                  18'h0A1A1, 18'h0A2A2, 18'h2A2A2,
                  18'h10700, 18'h0B0B0, 18'h0B0B0, 18'h0B1B1,
                  18'h2B1B1};
        run(1'b0, 1'b0, 1'b0, 80);
        idle_chk("vc_idle");

        // FIFO full: 16 accepted, 17th blocked until one pop
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_flit  = {2'b00, 16'(16'h1000 + i), 16'(16'h2000 + i)};
            in_valid = 3'b001;
            #1;
            chk("fill_ready", in_ready, 3'b001);
        end
        @(negedge clk);
        in_flit = {2'b10, 16'h1010, 16'h2010};
        #1;
        chk("full_ready_low", in_ready, 0);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("full_beat0", out_flit, 18'h01000);
        chk("full_ready_low2", in_ready, 0);
        @(negedge clk);
        #1;
        chk("full_beat1", out_flit, 18'h02000);
        chk("full_ready_low3", in_ready, 0);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("ready_after_pop", in_ready, 3'b001);
        @(negedge clk);
        in_valid = '0;
        for (int i = 1; i < 16; i++) begin
            exp_q.push_back({2'b00, 16'(16'h1000 + i)});
            exp_q.push_back({2'b00, 16'(16'h2000 + i)});
        end
        exp_q.push_back({2'b00, 16'h1010});
        exp_q.push_back({2'b10, 16'h2010});
        run(1'b0, 1'b0, 1'b0, 200);
        idle_chk("drain_idle");

        // reset after 2 of 3 beats of a locked header flit
        @(negedge clk);
        out_ready = 1'b1;
        in_flit   = {2'b01, 32'hABCD1234};
        in_valid  = 3'b010;
        #1;
        chk("mid_push_ready", in_ready, 3'b010);
        @(negedge clk);
        in_valid = '0;
        #1;
        chk("mid_beat0", out_flit, 18'h10700);
        @(negedge clk);
        #1;
        chk("mid_beat1", out_flit, 18'h0ABCD);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 3'b111;
        @(negedge clk);
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_flit", out_flit, 0);
        chk("mid_rst_ready", in_ready, 0);
        rst      = 1'b0;
        in_valid = 3'b100;
        in_flit  = {2'b11, 32'h55AA55AA};
        #1;
        chk("post_rst_ready", in_ready, 3'b100);
        exp_q = '{18'h10700, 18'h055AA, 18'h255AA};
        run(1'b0, 1'b1, 1'b0, 30);
        idle_chk("post_rst_idle");

        // GEN_HEADER=0, RATIO=4, LSB first
        begin
            logic [9:0] e1 [4];
            logic [9:0] e2 [8];
            e1 = '{10'h144, 10'h033, 10'h022, 10'h211};
            e2 = '{10'h1D4, 10'h0C3, 10'h0B2, 10'h0A1,
                   10'h004, 10'h003, 10'h002, 10'h201};
            @(negedge clk);
            d2_out_ready = 1'b1;
            d2_in_flit   = {2'b11, 32'h11223344};
            d2_in_valid  = 3'b001;
            #1;
            chk("d2_ready", d2_in_ready, 3'b001);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                d2_in_valid = '0;
                #1;
                chk("d2_single_valid", d2_out_valid, 1);
                chk("d2_single_beat", d2_out_flit, e1[k]);
            end
            @(negedge clk);
            #1;
            chk("d2_idle_valid", d2_out_valid, 0);
            chk("d2_idle_flit", d2_out_flit, 0);
            d2_in_flit  = {2'b01, 32'hA1B2C3D4};
            d2_in_valid = 3'b010;
            #1;
            chk("d2_hdr_ready", d2_in_ready, 3'b010);
            @(negedge clk);
            d2_in_flit = {2'b10, 32'h01020304};
            #1;
            chk("d2_last_ready", d2_in_ready, 3'b010);
            chk("d2_pkt_beat", d2_out_flit, e2[0]);
            for (int k = 1; k < 8; k++) begin
                @(negedge clk);
                d2_in_valid = '0;
                #1;
                chk("d2_pkt_valid", d2_out_valid, 1);
                chk("d2_pkt_beat", d2_out_flit, e2[k]);
            end
            @(negedge clk);
            #1;
            chk("d2_end_valid", d2_out_valid, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lisnoc_converter_downsize.md
LISNOC_CONVERTER_DOWNSIZE -- requirements
Module: lisnoc_converter_downsize

Interface
REQ-001 SHALL have parameter IN_DATA_WIDTH, default 32, meaning input flit data bits (type bits excluded).
REQ-002 SHALL have parameter RATIO, default 2, meaning output slices per input flit; legal 2..8, must divide IN_DATA_WIDTH; OUT_DATA_WIDTH = IN_DATA_WIDTH/RATIO.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning input flits buffered; power of two, >=2.
REQ-004 SHALL have parameter VCHANNELS_IN, default 3, meaning input virtual channels.
REQ-005 SHALL have parameters VCHANNELS_OUT (default 1) and OUT_VC (default 0), meaning output channel count and the one channel driven.
REQ-006 SHALL have parameter GEN_HEADER, default 1: 1 = prepend a generated header flit, 0 = reuse the first slice of the input header flit.
REQ-007 SHALL have parameters DEST (default 0, 5 bits) and PKT_CLASS (default 3'b111), meaning generated header fields.
REQ-008 SHALL have parameter MSB_FIRST, default 1, meaning slice order (1 = most significant slice first).
REQ-009 clk  input  1  clock; all state on rising edge.
REQ-010 rst  input  1  synchronous, active-high reset.
REQ-011 in_flit  input  IN_DATA_WIDTH+2  {type[1:0], data}; type 01 header, 00 payload, 10 last, 11 single.
REQ-012 in_valid  input  VCHANNELS_IN  per-VC valid.
REQ-013 in_ready  output  VCHANNELS_IN  per-VC ready.
REQ-014 out_flit  output  OUT_DATA_WIDTH+2  {type, data}, same type encoding.
REQ-015 out_valid  output  VCHANNELS_OUT  only bit OUT_VC is ever set.
REQ-016 out_ready  input  VCHANNELS_OUT  only bit OUT_VC is used.

Function
REQ-017 An input transfer on VC k SHALL occur when in_valid[k] and in_ready[k] are both high; at most one in_ready bit SHALL be high per cycle.
REQ-018 VC selection SHALL be round-robin among valid VCs and locked per packet: after a header is accepted on VC k, only in_ready[k] may assert until a last flit on k is accepted; a single flit SHALL not lock.
REQ-019 in_ready SHALL be low when the FIFO is full; a push and a pop in the same cycle on a full FIFO SHALL be disallowed (ready follows registered full).
REQ-020 Latency: a flit accepted at cycle t into an empty FIFO SHALL produce its first output beat (header or slice) with out_valid high at t+1.
REQ-021 The serializer FSM SHALL have states HDR and SLICE plus a slice counter 0..RATIO-1.
REQ-022 HDR (GEN_HEADER=1 only): when the FIFO head is a header or single flit, present out_flit = {01, DEST in data MSBs, PKT_CLASS below it, zeros elsewhere}; on out_ready go to SLICE, counter 0, no pop.
REQ-023 SLICE: present slice[counter] of the head flit; on out_ready increment the counter; on counter = RATIO-1 pop the head, reset the counter, and go to HDR after a last/single flit (GEN_HEADER=1), else stay in SLICE.
REQ-024 Slice types: final slice of a last/single input flit = 10; with GEN_HEADER=0, first slice of a header/single input flit = 01; all others = 00.
REQ-025 With GEN_HEADER=0 the FSM SHALL never enter HDR.
REQ-026 While out_valid is high and out_ready is low, out_flit and FSM state SHALL remain unchanged.
REQ-027 out_valid SHALL be low whenever the FIFO is empty; out_flit SHALL be zero when out_valid is low.
REQ-028 A payload or last flit arriving at an empty FSM in HDR SHALL be emitted as slices without a generated header (no deadlock).

Reset
REQ-029 While rst is high: out_valid=0, out_flit=0, in_ready=0, FIFO emptied, lock cleared, state = HDR (GEN_HEADER=1) or SLICE, counter 0, round-robin pointer = VC0.
REQ-030 Reset mid-packet SHALL discard all buffered and partially sent flits; the first cycle after reset SHALL accept a new flit.

Verification
REQ-031 Defaults, single flit 0xAABBCCDD, type 11 on VC0, out_ready=1 -> header {01,DEST,111}, then {00,0xAABB}, then {10,0xCCDD} on consecutive cycles.
REQ-032 Header+payload+last on VC1, out_ready toggling 1010 -> 7 output beats in order, out_flit stable during every stall.
REQ-033 VC0 and VC2 both valid with interleaved packets -> no interleave on output; whole VC0 packet first, then VC2.
REQ-034 Push 16 flits with out_ready=0 -> in_ready low at flit 17; one pop re-raises in_ready next cycle.
REQ-035 GEN_HEADER=0, RATIO=4, MSB_FIRST=0, single 0x11223344 -> {01,0x44},{00,0x33},{00,0x22},{10,0x11}, no generated header.
REQ-036 rst pulsed after 2 of 3 slices -> out_valid 0 next cycle; a subsequent packet is emitted complete and correctly typed.
